// File: rtl/ifu_fetch_if.sv
// Bundles the fetch stage's PC-register, imem and decode-side signals.
//   PC register side : pc, redirect -> fetch; pc_stall, pc_plus4 <- fetch
//   imem request     : imem_req_valid, imem_req_addr <- fetch; imem_req_ready -> fetch
//   imem response    : imem_resp_valid, imem_resp_data, imem_resp_err -> fetch
//   decode side      : if_valid, if_pc, if_inst, if_fault <- fetch; if_ready -> fetch
// master is the fetch sequencer's view, slave the surrounding pipeline/memory.
interface ifu_fetch_if;
  logic [31:0] pc;
  logic        redirect;
  logic        pc_stall;
  logic [31:0] pc_plus4;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_fault;

  modport master (
    input  pc, redirect, imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           if_ready,
    output pc_stall, pc_plus4, imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
           if_fault
  );

  modport slave (
    output pc, redirect, imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           if_ready,
    input  pc_stall, pc_plus4, imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
           if_fault
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch sequencer between the PC register and instruction memory.
// Issues one request per instruction, holds the returned word for decode, stalls the
// PC register until decode accepts, and discards responses made stale by a redirect.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - ifu_fetch_if.master: PC register, imem request/response and decode handshakes
// Parameters:
//   FAULT_INST - word presented on if_inst for a faulting fetch
//   TIMEOUT    - WAIT/DROP cycles before fault/abandon; 0 disables the timeout
module ifu_fetch #(
  parameter logic [31:0] FAULT_INST = 32'h0000_0013,
  parameter int unsigned TIMEOUT    = 256
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  // Wide enough to hold TIMEOUT + 1 so saturation never masks the compare.
  localparam int unsigned     CntW    = $clog2(TIMEOUT + 2);
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     if_pc_q, if_pc_d;
  logic [31:0]     if_inst_q, if_inst_d;
  logic            if_fault_q, if_fault_d;

  logic aligned;
  logic req_fire;
  logic dec_fire;
  logic timeout_hit;
  logic [CntW-1:0] cnt_inc;

  assign aligned  = (bus.pc[1:0] == 2'b00);
  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  assign dec_fire = (state_q == StHold) & bus.if_ready & ~bus.redirect;
  // The cycle in which the counter shows TIMEOUT-1 is the TIMEOUT-th waiting cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= CntLast);
  assign cnt_inc     = (cnt_q != CntMax) ? cnt_q + 1'b1 : cnt_q;

  // Outputs
  assign bus.imem_req_valid = (state_q == StReq) & ~bus.redirect & aligned & ~rst;
  assign bus.imem_req_addr  = bus.pc;
  assign bus.pc_plus4       = bus.pc + 32'd4;
  // Reset keeps the PC register frozen even if redirect is asserted.
  assign bus.pc_stall       = rst | ~(dec_fire | bus.redirect);
  assign bus.if_valid       = (state_q == StHold);
  assign bus.if_pc          = if_pc_q;
  assign bus.if_inst        = if_inst_q;
  assign bus.if_fault       = if_fault_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_fault_d = if_fault_q;

    unique case (state_q)
      StReq: begin
        if (bus.redirect) begin
          state_d = StReq;
        end else if (!aligned) begin
          state_d    = StHold;
          if_pc_d    = bus.pc;
          if_inst_d  = FAULT_INST;
          if_fault_d = 1'b1;
        end else if (req_fire) begin
          state_d = StWait;
          cnt_d   = '0;
          if_pc_d = bus.pc;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (bus.imem_resp_valid) begin
          if (bus.redirect) begin
            state_d = StReq;
          end else begin
            state_d    = StHold;
            if_inst_d  = bus.imem_resp_err ? FAULT_INST : bus.imem_resp_data;
            if_fault_d = bus.imem_resp_err;
          end
        end else if (bus.redirect) begin
          // Response still owed by imem; it must be swallowed before re-requesting.
          state_d = StDrop;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d    = StHold;
          if_inst_d  = FAULT_INST;
          if_fault_d = 1'b1;
        end
      end
      StDrop: begin
        cnt_d = cnt_inc;
        if (bus.imem_resp_valid || timeout_hit) begin
          state_d = StReq;
        end
      end
      StHold: begin
        if (bus.redirect || bus.if_ready) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      cnt_q      <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_fault_q <= if_fault_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch (TIMEOUT=4). Inputs change 1 time unit after each rising
// edge; outputs are checked 1 time unit later, well clear of the next edge.
module tb_ifu_fetch;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ifu_fetch_if bus ();

  ifu_fetch #(
    .FAULT_INST(32'h0000_0013),
    .TIMEOUT   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst                 = 1'b1;
    bus.pc              = 32'h8000_0000;
    bus.redirect        = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b0;
    bus.if_ready        = 1'b0;

    // Reset state; redirect during reset must not release the PC register.
    tick();
    tick();
    bus.redirect = 1'b1;
    #1;
    check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("rst_pc_stall", {31'b0, bus.pc_stall}, 32'd1);
    check("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_if_inst", bus.if_inst, 32'h0);
    check("rst_if_fault", {31'b0, bus.if_fault}, 32'd0);
    bus.redirect = 1'b0;

    // Back-to-back fetch: req T, resp T+1, if_valid T+2 with pc_stall=0.
    tick();
    rst = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    #1;
    check("t1_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("t1_req_addr", bus.imem_req_addr, 32'h8000_0000);
    check("t1_pc_plus4", bus.pc_plus4, 32'h8000_0004);
    check("t1_stall_req", {31'b0, bus.pc_stall}, 32'd1);
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'h0010_0093;
    #1;
    check("t1_wait_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("t1_wait_if_valid", {31'b0, bus.if_valid}, 32'd0);
    tick();
    bus.imem_resp_valid = 1'b0;
    #1;
    check("t1_if_valid", {31'b0, bus.if_valid}, 32'd1);
    check("t1_if_pc", bus.if_pc, 32'h8000_0000);
    check("t1_if_inst", bus.if_inst, 32'h0010_0093);
    check("t1_if_fault", {31'b0, bus.if_fault}, 32'd0);
    check("t1_fire_stall", {31'b0, bus.pc_stall}, 32'd0);

    // Decode stalls 5 cycles in HOLD.
    tick();
    bus.pc = 32'h8000_0004;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b0;
    #1;
    check("t2_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("t2_req_addr", bus.imem_req_addr, 32'h8000_0004);
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'h0020_8113;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.imem_resp_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      #1;
      check("t2_hold_valid", {31'b0, bus.if_valid}, 32'd1);
      check("t2_hold_inst", bus.if_inst, 32'h0020_8113);
      check("t2_hold_stall", {31'b0, bus.pc_stall}, 32'd1);
      check("t2_hold_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
    end
    bus.imem_req_ready = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    check("t2_fire_stall", {31'b0, bus.pc_stall}, 32'd0);

    // Redirect while waiting: stale 0xDEADBEEF is swallowed in DROP.
    tick();
    bus.pc = 32'h8000_0008;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b0;
    #1;
    check("t3_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect = 1'b1;
    #1;
    check("t3_redir_stall", {31'b0, bus.pc_stall}, 32'd0);
    tick();
    bus.redirect = 1'b0;
    bus.pc = 32'h8000_1000;
    bus.imem_req_ready = 1'b1;
    #1;
    check("t3_drop_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'hDEAD_BEEF;
    #1;
    check("t3_drop_if_valid", {31'b0, bus.if_valid}, 32'd0);
    tick();
    bus.imem_resp_valid = 1'b0;
    #1;
    check("t3_after_drop_valid", {31'b0, bus.if_valid}, 32'd0);
    check("t3_target_req", {31'b0, bus.imem_req_valid}, 32'd1);
    check("t3_target_addr", bus.imem_req_addr, 32'h8000_1000);
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'h0000_0033;
    #1;
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    check("t3_new_inst", bus.if_inst, 32'h0000_0033);
    check("t3_new_pc", bus.if_pc, 32'h8000_1000);

    // Misaligned PC: no request, fault word presented.
    tick();
    bus.pc = 32'h8000_0002;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b0;
    #1;
    check("t4_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
    check("t4_stall", {31'b0, bus.pc_stall}, 32'd1);
    tick();
    bus.imem_req_ready = 1'b0;
    #1;
    check("t4_valid", {31'b0, bus.if_valid}, 32'd1);
    check("t4_fault", {31'b0, bus.if_fault}, 32'd1);
    check("t4_inst", bus.if_inst, 32'h0000_0013);
    check("t4_pc", bus.if_pc, 32'h8000_0002);
    bus.if_ready = 1'b1;

    // Bus error response.
    tick();
    bus.pc = 32'h8000_0010;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b0;
    #1;
    check("t5_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_err = 1'b1;
    bus.imem_resp_data = 32'h1234_5678;
    #1;
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_err = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    check("t5_fault", {31'b0, bus.if_fault}, 32'd1);
    check("t5_inst", bus.if_inst, 32'h0000_0013);
    check("t5_pc", bus.if_pc, 32'h8000_0010);

    // Timeout after 4 WAIT cycles with no response.
    tick();
    bus.pc = 32'h8000_0014;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b0;
    #1;
    check("t6_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.imem_req_ready = 1'b0;
      #1;
      check("t6_wait_no_valid", {31'b0, bus.if_valid}, 32'd0);
    end
    tick();
    #1;
    check("t6_to_valid", {31'b0, bus.if_valid}, 32'd1);
    check("t6_to_fault", {31'b0, bus.if_fault}, 32'd1);
    check("t6_to_inst", bus.if_inst, 32'h0000_0013);
    check("t6_to_pc", bus.if_pc, 32'h8000_0014);

    // Redirect together with if_ready in HOLD: word dropped, back to REQ.
    bus.redirect = 1'b1;
    bus.if_ready = 1'b1;
    #1;
    check("t7_stall", {31'b0, bus.pc_stall}, 32'd0);
    tick();
    bus.redirect = 1'b0;
    bus.if_ready = 1'b0;
    bus.pc = 32'h8000_2000;
    #1;
    check("t7_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check("t7_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("t7_req_addr", bus.imem_req_addr, 32'h8000_2000);
    bus.pc = 32'hFFFF_FFFC;
    #1;
    check("t7_pc_plus4_wrap", bus.pc_plus4, 32'h0000_0000);

    // DROP abandons after 4 cycles; a late response is then ignored.
    bus.imem_req_ready = 1'b1;
    #1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.redirect = 1'b0;
      bus.pc = 32'h8000_3000;
      #1;
      check("t8_drop_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
    end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'hCAFE_F00D;
    #1;
    check("t8_abandon_req", {31'b0, bus.imem_req_valid}, 32'd1);
    check("t8_abandon_addr", bus.imem_req_addr, 32'h8000_3000);
    tick();
    bus.imem_resp_valid = 1'b0;
    #1;
    check("t8_late_no_valid", {31'b0, bus.if_valid}, 32'd0);
    check("t8_late_req", {31'b0, bus.imem_req_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
